ift_trace_recorder: RTL and testbench



---
 rtl/ift_trace_recorder.sv | 229 ++++++++++++++++++++++
 tb/tb_ift_trace_recorder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ift_trace_recorder.sv
// -----------------------------------------------------------------------------
// ift_trace_recorder
//
// Records change events of an IFT-instrumented flip-flop's output (Q and its
// taint vector Q_t). While capturing, every cycle whose value or taint differs
// from the previous cycle (and always the first cycle) produces an event
// {value, taint, timestamp}, which is pushed into a circular FIFO. A reader
// drains the FIFO through a show-ahead valid/ready port.
//
// Ports:
//   CLK        clock, all state changes on the rising edge
//   RST        synchronous active-high reset
//   ARM        start a capture (honoured in IDLE only)
//   STOP       end a capture (honoured in CAPTURE only); that cycle is sampled
//   Q, Q_t     DUT value and taint being recorded
//   OUT_VALID  FIFO head holds an event
//   OUT_READY  reader accepts the head event
//   OUT_DATA   head event value
//   OUT_TAINT  head event taint
//   OUT_TS     head event timestamp
//   COUNT      number of buffered events
//   OVERFLOW   sticky: an event was dropped since the last ARM/RST
//   BUSY       recorder is capturing or draining
// -----------------------------------------------------------------------------
module ift_trace_recorder #(
    parameter int DATA_W  = 2,
    parameter int TAINT_W = 32,
    parameter int DEPTH   = 16,
    parameter int TS_W    = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ARM,
    input  logic                     STOP,
    input  logic [DATA_W-1:0]        Q,
    input  logic [TAINT_W-1:0]       Q_t,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [DATA_W-1:0]        OUT_DATA,
    output logic [TAINT_W-1:0]       OUT_TAINT,
    output logic [TS_W-1:0]          OUT_TS,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERFLOW,
    output logic                     BUSY
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int EV_W  = DATA_W + TAINT_W + TS_W;

    localparam logic [TS_W-1:0]  TS_MAX    = {TS_W{1'b1}};
    localparam logic [TS_W-1:0]  TS_ONE    = TS_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_arm_acc;

    logic [EV_W-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;

    logic [TS_W-1:0]    r_ts;
    logic               r_first;
    logic [DATA_W-1:0]  r_prev_q;
    logic [TAINT_W-1:0] r_prev_t;
    logic               r_overflow;

    logic               w_sample;
    logic               w_push_req;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic               w_empty;
    logic               w_full;
    logic [EV_W-1:0]    w_head;

    // Event detection and FIFO handshake decisions for this cycle.
    always_comb begin
        w_sample   = 1'b0;
        w_push_req = 1'b0;
        w_empty    = (r_count == CNT_ZERO);
        w_full     = (r_count == CNT_DEPTH);
        w_pop      = 1'b0;
        w_push     = 1'b0;
        w_drop     = 1'b0;
        if (r_state == ST_CAPTURE) begin
            w_sample   = 1'b1;
            w_push_req = r_first | (Q != r_prev_q) | (Q_t != r_prev_t);
        end else begin
            w_sample   = 1'b0;
            w_push_req = 1'b0;
        end
        w_pop = ~w_empty & OUT_READY;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        w_push = w_push_req & (~w_full | w_pop);
        w_drop = w_push_req & ~w_push;
    end

    // Occupancy after this cycle's push/pop.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_ONE;
            2'b01:   w_count_next = r_count - CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Next-state logic; DRAIN ends on the edge that empties the FIFO.
    always_comb begin
        w_state_next = r_state;
        w_arm_acc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ARM) begin
                    w_state_next = ST_CAPTURE;
                    w_arm_acc    = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (STOP) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_DRAIN: begin
                if (w_count_next == CNT_ZERO) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture bookkeeping: timestamp, first-sample flag, previous sample, overflow.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ts       <= {TS_W{1'b0}};
            r_first    <= 1'b0;
            r_prev_q   <= {DATA_W{1'b0}};
            r_prev_t   <= {TAINT_W{1'b0}};
            r_overflow <= 1'b0;
        end else if (w_arm_acc) begin
            r_ts       <= {TS_W{1'b0}};
            r_first    <= 1'b1;
            r_overflow <= 1'b0;
        end else if (w_sample) begin
            r_prev_q <= Q;
            r_prev_t <= Q_t;
            r_first  <= 1'b0;
            // Saturate rather than wrap so late events never look early.
            if (r_ts != TS_MAX) begin
                r_ts <= r_ts + TS_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; reset discards everything buffered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= CNT_ZERO;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_next;
        end
    end

    // Event storage; contents are only observable through a valid head.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {Q, Q_t, r_ts};
        end
    end

    // Head is forced to zero when empty so outputs read 0 after reset.
    always_comb begin
        w_head = {EV_W{1'b0}};
        if (!w_empty) begin
            w_head = r_mem[r_rd_ptr];
        end else begin
            w_head = {EV_W{1'b0}};
        end
    end

    assign OUT_VALID = ~w_empty;
    assign {OUT_DATA, OUT_TAINT, OUT_TS} = w_head;
    assign COUNT     = r_count;
    assign OVERFLOW  = r_overflow;
    assign BUSY      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ift_trace_recorder.sv
module tb_ift_trace_recorder;

    localparam int DATA_W  = 2;
    localparam int TAINT_W = 32;
    localparam int DEPTH   = 16;
    localparam int TS_W    = 16;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic                 ARM;
    logic                 STOP;
    logic [DATA_W-1:0]    Q;
    logic [TAINT_W-1:0]   Q_t;
    logic                 OUT_VALID;
    logic                 OUT_READY;
    logic [DATA_W-1:0]    OUT_DATA;
    logic [TAINT_W-1:0]   OUT_TAINT;
    logic [TS_W-1:0]      OUT_TS;
    logic [4:0]           COUNT;
    logic                 OVERFLOW;
    logic                 BUSY;

    ift_trace_recorder #(
        .DATA_W (DATA_W),
        .TAINT_W(TAINT_W),
        .DEPTH  (DEPTH),
        .TS_W   (TS_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .ARM      (ARM),
        .STOP     (STOP),
        .Q        (Q),
        .Q_t      (Q_t),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .OUT_DATA (OUT_DATA),
        .OUT_TAINT(OUT_TAINT),
        .OUT_TS   (OUT_TS),
        .COUNT    (COUNT),
        .OVERFLOW (OVERFLOW),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0]  d;
        logic [31:0] t;
        logic [15:0] ts;
    } ev_t;

    ev_t sb[$];
    ev_t pop_log[$];
    int  n_vec = 0;
    int  n_err = 0;

    // reference model state
    int          m_mode  = 0;   // 0 idle, 1 capture, 2 drain
    int          m_count = 0;
    bit          m_ovf   = 1'b0;
    bit          m_first = 1'b0;
    int          m_ts    = 0;
    logic [1:0]  m_pq    = 2'b00;
    logic [31:0] m_pt    = 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: applies the recorder's rules once per rising edge.
    task automatic model_step();
        int  old_mode;
        bit  pop;
        bit  push;
        ev_t e;
        if (RST) begin
            m_mode = 0; m_count = 0; m_ovf = 1'b0; m_first = 1'b0; m_ts = 0;
            sb.delete();
        end else begin
            old_mode = m_mode;
            pop  = (m_count > 0) && OUT_READY;
            push = 1'b0;
            e    = '0;
            if (m_mode == 0) begin
                if (ARM) begin
                    m_mode = 1; m_ts = 0; m_ovf = 1'b0; m_first = 1'b1;
                end
            end else if (m_mode == 1) begin
                if (m_first || Q !== m_pq || Q_t !== m_pt) begin
                    push = 1'b1;
                    e    = {Q, Q_t, 16'(m_ts)};
                end
                m_pq = Q; m_pt = Q_t; m_first = 1'b0;
                if (m_ts < 65535) m_ts++;
                if (STOP) m_mode = 2;
            end
            if (push) begin
                if (m_count < DEPTH || pop) begin
                    sb.push_back(e);
                    m_count++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (pop) m_count--;
            if (old_mode == 2 && m_count == 0) m_mode = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            model_step();
        end
    end

    // Monitor: compare status every cycle, pop scoreboard on each handshake.
    initial begin
        ev_t e;
        ev_t a;
        forever begin
            @(negedge CLK);
            check("out_valid", 64'(OUT_VALID), 64'(m_count != 0));
            check("count", 64'(COUNT), 64'(m_count));
            check("overflow", 64'(OVERFLOW), 64'(m_ovf));
            check("busy", 64'(BUSY), 64'(m_mode != 0));
            if (OUT_VALID && OUT_READY) begin
                a = {OUT_DATA, OUT_TAINT, OUT_TS};
                pop_log.push_back(a);
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_event actual=%0h expected=none", a);
                end else begin
                    e = sb.pop_front();
                    check("event", 64'(a), 64'(e));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        OUT_READY = 1'b1;
        while (BUSY && i < budget) begin
            tick();
            i++;
        end
        check("drain_timeout", 64'(BUSY), 64'(0));
    endtask

    task automatic check_log(input string name, input int n, input int q_mask);
        check({name, "_len"}, 64'(pop_log.size()), 64'(n));
        for (int j = 0; j < n; j++) begin
            if (j < pop_log.size()) begin
                check({name, "_ts"}, 64'(pop_log[j].ts), 64'(j));
                check({name, "_data"}, 64'(pop_log[j].d), 64'(j & q_mask));
            end
        end
    endtask

    initial begin
        RST = 1'b1; ARM = 1'b0; STOP = 1'b0; OUT_READY = 1'b1;
        Q = 2'b01; Q_t = 32'h0;

        // reset / idle
        for (int i = 0; i < 2; i++) begin
            Q_t = ~Q_t;
            tick();
        end
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            Q_t = ~Q_t;
            tick();
        end
        check("idle_count", 64'(COUNT), 64'(0));
        check("idle_valid", 64'(OUT_VALID), 64'(0));
        check("idle_data", 64'({OUT_DATA, OUT_TAINT, OUT_TS}), 64'(0));

        // change detection
        pop_log.delete();
        ARM = 1'b1; tick(); ARM = 1'b0;
        Q = 2'b00; Q_t = 32'h0;
        for (int i = 0; i < 3; i++) tick();
        Q = 2'b01;
        for (int i = 0; i < 2; i++) tick();
        Q_t = 32'h1; STOP = 1'b1; tick(); STOP = 1'b0;
        check("cd_busy_before_last_pop", 64'(BUSY), 64'(1));
        tick();
        check("cd_busy_after_last_pop", 64'(BUSY), 64'(0));
        check("cd_len", 64'(pop_log.size()), 64'(3));
        if (pop_log.size() == 3) begin
            check("cd_ev0", 64'(pop_log[0]), 64'({2'b00, 32'h0, 16'd0}));
            check("cd_ev1", 64'(pop_log[1]), 64'({2'b01, 32'h0, 16'd3}));
            check("cd_ev2", 64'(pop_log[2]), 64'({2'b01, 32'h1, 16'd5}));
        end

        // backpressure
        OUT_READY = 1'b0; Q_t = 32'h1;
        ARM = 1'b1; tick(); ARM = 1'b0;
        for (int i = 0; i < 4; i++) begin
            Q = 2'(i);
            STOP = (i == 3);
            tick();
            check("bp_head_data", 64'(OUT_DATA), 64'(0));
            check("bp_head_ts", 64'(OUT_TS), 64'(0));
        end
        STOP = 1'b0;
        check("bp_count", 64'(COUNT), 64'(4));
        pop_log.delete();
        OUT_READY = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            check("bp_drain_count", 64'(COUNT), 64'(3 - j));
        end
        check_log("bp", 4, 3);
        check("bp_busy", 64'(BUSY), 64'(0));

        // overflow
        OUT_READY = 1'b0;
        ARM = 1'b1; tick(); ARM = 1'b0;
        for (int i = 0; i < 20; i++) begin
            Q = 2'(i); Q_t = 32'(i); STOP = (i == 19);
            tick();
        end
        STOP = 1'b0;
        check("ovf_count", 64'(COUNT), 64'(16));
        check("ovf_flag", 64'(OVERFLOW), 64'(1));
        pop_log.delete();
        wait_idle(40);
        check_log("ovf", 16, 3);
        check("ovf_held", 64'(OVERFLOW), 64'(1));
        ARM = 1'b1; tick(); ARM = 1'b0;
        check("ovf_cleared_by_arm", 64'(OVERFLOW), 64'(0));
        STOP = 1'b1; tick(); STOP = 1'b0;
        wait_idle(10);

        // full with simultaneous push and pop
        pop_log.delete();
        OUT_READY = 1'b0;
        ARM = 1'b1; tick(); ARM = 1'b0;
        for (int i = 0; i < 24; i++) begin
            Q = 2'(i); Q_t = 32'(i + 100);
            if (i == 16) OUT_READY = 1'b1;
            STOP = (i == 23);
            tick();
            if (i >= 15) begin
                check("full_count", 64'(COUNT), 64'(16));
                check("full_no_ovf", 64'(OVERFLOW), 64'(0));
            end
        end
        STOP = 1'b0;
        wait_idle(40);
        check_log("full", 24, 3);

        // reset mid-capture
        OUT_READY = 1'b0;
        ARM = 1'b1; tick(); ARM = 1'b0;
        for (int i = 0; i < 5; i++) begin
            Q = 2'(i + 1);
            tick();
        end
        check("rst_pre_count", 64'(COUNT), 64'(5));
        RST = 1'b1; tick(); RST = 1'b0;
        check("rst_count", 64'(COUNT), 64'(0));
        check("rst_valid", 64'(OUT_VALID), 64'(0));
        check("rst_busy", 64'(BUSY), 64'(0));
        pop_log.delete();
        OUT_READY = 1'b1;
        ARM = 1'b1; tick(); ARM = 1'b0;
        Q = 2'b10; tick();
        Q = 2'b11; STOP = 1'b1; tick(); STOP = 1'b0;
        wait_idle(10);
        check("rst_rearm_len", 64'(pop_log.size()), 64'(2));
        if (pop_log.size() > 0) begin
            check("rst_rearm_ts0", 64'(pop_log[0].ts), 64'(0));
        end

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            RST       = ($urandom_range(0, 199) == 0);
            ARM       = ($urandom_range(0, 7) == 0);
            STOP      = ($urandom_range(0, 23) == 0);
            OUT_READY = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) Q = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) Q_t = Q_t ^ (32'h1 << $urandom_range(0, 31));
            tick();
        end
        RST = 1'b0; ARM = 1'b0; OUT_READY = 1'b1;
        STOP = 1'b1; tick(); STOP = 1'b0;
        wait_idle(40);
        check("final_scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
